// File: rtl/ex_div_unit.sv
// Iterative 32-bit radix-2 restoring divider for DIV/DIVU in the execute stage.
// Returns {remainder, quotient} after 34 cycles; divide-by-zero resolves in 2.
`timescale 1ns/1ps
module ex_div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_FREE, S_BY_ZERO, S_ON, S_END} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt, cnt_nxt;
  logic [63:0] work, work_nxt;
  logic [31:0] dvsr_abs, dvsr_nxt;
  logic        sign1, sign1_nxt;
  logic        sign2, sign2_nxt;
  logic [63:0] result_nxt;
  logic        ready_nxt;
  logic [64:0] w_shift;
  logic [32:0] trial;

  function automatic logic [31:0] mag(input logic signed [31:0] v, input logic is_signed);
    return (is_signed && v < 0) ? unsigned'(-v) : unsigned'(v);
  endfunction

  function automatic logic [31:0] fix_sign(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    work_nxt   = work;
    dvsr_nxt   = dvsr_abs;
    sign1_nxt  = sign1;
    sign2_nxt  = sign2;
    result_nxt = result_o;
    ready_nxt  = ready_o;
    w_shift    = {work, 1'b0};
    trial      = w_shift[64:32] - {1'b0, dvsr_abs};
    case (state)
      S_FREE: begin
        ready_nxt  = 1'b0;
        result_nxt = '0;
        if (start_i && !annul_i) begin
          if (opdata2_i == 32'd0) begin
            state_nxt = S_BY_ZERO;
          end else begin
            state_nxt = S_ON;
            sign1_nxt = signed_div_i & opdata1_i[31];
            sign2_nxt = signed_div_i & opdata2_i[31];
            work_nxt  = {32'd0, mag($signed(opdata1_i), signed_div_i)};
            dvsr_nxt  = mag($signed(opdata2_i), signed_div_i);
            cnt_nxt   = 6'd0;
          end
        end
      end
      S_BY_ZERO: begin
        state_nxt  = S_END;
        result_nxt = '0;
        ready_nxt  = 1'b1;
      end
      S_ON: begin
        if (annul_i || !start_i) begin
          state_nxt  = S_FREE;
          cnt_nxt    = 6'd0;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end else if (cnt != 6'd32) begin
          // Restore on a negative trial; otherwise keep the difference and shift in a 1
          work_nxt = trial[32] ? w_shift[63:0] : {trial[31:0], w_shift[31:1], 1'b1};
          cnt_nxt  = cnt + 6'd1;
        end else begin
          result_nxt = {fix_sign(work[63:32], sign1), fix_sign(work[31:0], sign1 ^ sign2)};
          ready_nxt  = 1'b1;
          state_nxt  = S_END;
        end
      end
      S_END: begin
        if (!start_i) begin
          state_nxt  = S_FREE;
          ready_nxt  = 1'b0;
          result_nxt = '0;
        end
      end
      default: state_nxt = S_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_FREE;
      cnt      <= 6'd0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      result_o <= result_nxt;
      ready_o  <= ready_nxt;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use
  always_ff @(posedge clk) begin
    work     <= work_nxt;
    dvsr_abs <= dvsr_nxt;
    sign1    <= sign1_nxt;
    sign2    <= sign2_nxt;
  end

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed testbench for ex_div_unit: results, latency, abort, reset and back-to-back requests.
`timescale 1ns/1ps
module tb_ex_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;
  int          errors = 0;
  int          checks = 0;

  ex_div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div),
    .opdata1_i    (op1),
    .opdata2_i    (op2),
    .start_i      (start),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready)
  );

  always #5 clk = ~clk;

  task automatic do_div(input string name, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp,
                        input int exp_lat, input bit hold);
    int lat;
    @(negedge clk);
    signed_div = sd; op1 = a; op2 = b; start = 1'b1; annul = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ready && lat < 40);
    checks++;
    if (lat !== exp_lat) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (result !== exp) begin
      errors++; $display("FAIL %s_result: got %h expected %h", name, result, exp);
    end
    if (hold) begin
      @(posedge clk); #1;
      checks++;
      if (ready !== 1'b1 || result !== exp) begin
        errors++; $display("FAIL %s_hold: got %b/%h expected 1/%h", name, ready, result, exp);
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL %s_drop: got %b/%h expected 0/0", name, ready, result);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    #3;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ready); end
    checks++;
    if (result !== 64'd0) begin errors++; $display("FAIL reset_result: got %h expected 0", result); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_unsigned;
    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b1);
    do_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2, {32'h1, 32'h7FFFFFFC}, 34, 1'b0);
    do_div("u_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, {32'h0, 32'hFFFFFFFF}, 34, 1'b0);
  endtask

  task automatic test_signed;
    do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 1'b0);
    do_div("s_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, {32'h1, 32'hFFFFFFFD}, 34, 1'b0);
    do_div("s_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, {32'hFFFFFFFE, 32'hE}, 34, 1'b0);
    do_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 34, 1'b0);
  endtask

  task automatic test_by_zero;
    do_div("by_zero", 1'b0, 32'h12345678, 32'd0, 64'd0, 2, 1'b1);
  endtask

  task automatic test_annul;
    bit rose = 0;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0; start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL annul_no_ready: got ready=1 expected 0"); end
    do_div("after_annul", 1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 34, 1'b0);
  endtask

  task automatic test_annul_priority;
    bit rose = 0;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd20; op2 = 32'd6; start = 1'b1; annul = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL prio_ready: got 1 expected 0"); end
    do_div("prio", 1'b0, 32'd20, 32'd6, {32'h2, 32'h3}, 34, 1'b0);
  endtask

  task automatic test_reset_mid;
    bit rose = 0;
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      errors++; $display("FAIL rst_mid_on: got %b/%h expected 0/0", ready, result);
    end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    op1 = 32'h12345678; op2 = 32'd0; start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rst_pre_end: got %b expected 1", ready); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL rst_async_end: got %b expected 0", ready); end
    @(negedge clk);
    rst = 1'b1; start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready !== 1'b0) rose = 1;
    end
    checks++;
    if (rose) begin errors++; $display("FAIL rst_idle: got ready=1 expected 0"); end
    do_div("after_rst", 1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 34, 1'b0);
  endtask

  task automatic test_back_to_back;
    do_div("b2b_a", 1'b0, 32'd20, 32'd6, {32'h2, 32'h3}, 34, 1'b0);
    do_div("b2b_b", 1'b0, 32'hFFFFFFFF, 32'h10, {32'hF, 32'h0FFFFFFF}, 34, 1'b0);
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_by_zero;
    test_annul;
    test_annul_priority;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
